pipe_drain_ctrl: RTL and testbench

Consumer-side controller for the multiply/add datapath pipeline: it tracks which pipeline slots hold valid operands, captures each finished result into a small output buffer, and drives the `can_mult` back-pressure signal consumed by the issue-side pipe controller. It is the receiving end of the `ld_mult`/`ld_add`/`can_mult` handshake. It uses credit accounting so that no result issued into the pipeline can ever find the buffer full.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/result_fifo.sv | 63 ++++++
 rtl/pipe_drain_ctrl.sv | 80 ++++++++
 tb/tb_pipe_drain_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline sizing constants, also used by the issue-side controller.
package pipe_pkg;

  localparam int unsigned PipeDepthDef = 2;
  localparam int unsigned BufDepthDef  = 4;
  localparam int unsigned DataWDef     = 16;

endpackage

// File: rtl/result_fifo.sv
// Synchronous show-ahead result FIFO; writes when full and reads when empty are dropped.
module result_fifo #(
  parameter int unsigned BUF_DEPTH = 4,
  parameter int unsigned DATA_W    = 16,
  localparam int unsigned PtrW     = $clog2(BUF_DEPTH),
  localparam int unsigned CntW     = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic              rd,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [CntW-1:0]   count,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              wr_ok, rd_ok;

  always_comb begin
    full     = (count_q == CntW'(BUF_DEPTH));
    empty    = (count_q == '0);
    wr_ok    = wr & ~full;
    rd_ok    = rd & ~empty;
    // Depth is a power of two, so pointers wrap on their own.
    wr_ptr_d = wr_ptr_q + PtrW'(wr_ok);
    rd_ptr_d = rd_ptr_q + PtrW'(rd_ok);
    count_d  = count_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/pipe_drain_ctrl.sv
// Consumer side of the ld_mult/ld_add/can_mult handshake: token tracking, result
// buffering and credit-based back-pressure.
module pipe_drain_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned PIPE_DEPTH = PipeDepthDef,
  parameter int unsigned BUF_DEPTH  = BufDepthDef,
  parameter int unsigned DATA_W     = DataWDef,
  localparam int unsigned CntW      = $clog2(BUF_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_mult,
  input  logic              ld_add,
  input  logic [DATA_W-1:0] res_in,
  input  logic              rd_en,
  output logic              can_mult,
  output logic [DATA_W-1:0] res_out,
  output logic              res_valid,
  output logic [CntW-1:0]   count,
  output logic              ovf
);

  localparam int unsigned ComW = $clog2(BUF_DEPTH + PIPE_DEPTH + 1);

  logic [PIPE_DEPTH-1:0] inflight_q, inflight_d;
  logic                  ovf_q, ovf_d;
  logic                  wr;
  logic                  fifo_full, fifo_empty;
  logic [ComW-1:0]       pop;
  logic [ComW-1:0]       committed;

  always_comb begin
    inflight_d = inflight_q;
    if (ld_add) begin
      inflight_d = {inflight_q[PIPE_DEPTH-2:0], ld_mult};
    end
    wr    = ld_add & inflight_q[PIPE_DEPTH-1];
    ovf_d = ovf_q | (wr & fifo_full);
  end

  // Credits come from registered state only, keeping can_mult off any input path.
  always_comb begin
    pop = '0;
    for (int i = 0; i < PIPE_DEPTH; i++) begin
      pop = pop + ComW'(inflight_q[i]);
    end
    committed = ComW'(count) + pop;
    can_mult  = (committed < ComW'(BUF_DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      ovf_q      <= ovf_d;
    end
  end

  result_fifo #(
    .BUF_DEPTH (BUF_DEPTH),
    .DATA_W    (DATA_W)
  ) u_result_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (wr),
    .rd    (rd_en),
    .wdata (res_in),
    .rdata (res_out),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res_valid = ~fifo_empty;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_drain_ctrl.sv
// Scoreboard bench for pipe_drain_ctrl at default parameters.
module tb_pipe_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_mult, ld_add, rd_en;
  logic [15:0] res_in;
  logic        can_mult, res_valid, ovf;
  logic [15:0] res_out;
  logic [2:0]  count;

  int          n_checks = 0;
  int          n_bad    = 0;

  // Reference model state
  int          q[$];
  logic [1:0]  tok;
  logic        movf;
  int          next_val;

  always #5 clk = ~clk;

  pipe_drain_ctrl u_dut (
    .clk       (clk),
    .rst       (rst),
    .ld_mult   (ld_mult),
    .ld_add    (ld_add),
    .res_in    (res_in),
    .rd_en     (rd_en),
    .can_mult  (can_mult),
    .res_out   (res_out),
    .res_valid (res_valid),
    .count     (count),
    .ovf       (ovf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int pc;
    pc = int'(tok[0]) + int'(tok[1]);
    check_eq("count", 32'(count), 32'(q.size()));
    check_eq("res_valid", 32'(res_valid), 32'(q.size() > 0));
    check_eq("can_mult", 32'(can_mult), 32'((q.size() + pc) < 4));
    check_eq("ovf", 32'(ovf), 32'(movf));
  endtask

  // One clock: drive, pop/compare on read, update model, sample after the edge.
  task automatic cycle(input logic m, input logic a, input logic r, input logic [15:0] d);
    logic full, wr;
    int   exp;
    ld_mult = m;
    ld_add  = a;
    rd_en   = r;
    res_in  = d;
    full    = (q.size() == 4);
    wr      = a & tok[1];
    if (r && q.size() > 0) begin
      exp = q.pop_front();
      check_eq("head", 32'(res_out), 32'(exp));
    end
    if (wr) begin
      if (full) movf = 1'b1;
      else q.push_back(int'(d));
    end
    if (a) tok = {tok[0], m};
    @(posedge clk);
    #1;
    check_state();
  endtask

  // Supplies the next sequence value exactly when a token sits in the last stage.
  task automatic auto_cycle(input logic m, input logic r);
    logic [15:0] d;
    d = 16'h0;
    if (tok[1]) begin
      d = 16'(next_val);
      next_val++;
    end
    cycle(m, 1'b1, r, d);
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1;
    repeat (ncyc) begin
      ld_mult = 1'($urandom);
      ld_add  = 1'($urandom);
      rd_en   = 1'($urandom);
      res_in  = 16'($urandom);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    ld_mult = 1'b0;
    ld_add  = 1'b0;
    rd_en   = 1'b0;
    res_in  = '0;
    q.delete();
    tok  = '0;
    movf = 1'b0;
    check_eq("rst_can_mult", 32'(can_mult), 32'd1);
    check_eq("rst_valid", 32'(res_valid), 32'd0);
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
  endtask

  initial begin
    int          accepted;
    logic [15:0] head;
    next_val = 1;
    rst = 1'b1;
    ld_mult = 1'b0;
    ld_add = 1'b0;
    rd_en = 1'b0;
    res_in = '0;
    tok = '0;
    movf = 1'b0;

    do_reset(2);

    // Single token with ld_add held high: visible three cycles after issue
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h00A5);
    check_eq("single_valid", 32'(res_valid), 32'd1);
    check_eq("single_out", 32'(res_out), 32'h00A5);
    check_eq("single_count", 32'(count), 32'd1);
    cycle(1'b0, 1'b0, 1'b1, 16'h0);

    // Fill gated by can_mult, no reads
    accepted = 0;
    next_val = 1;
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) check_eq("fill_stop", 32'(can_mult), 32'd0);
      if (can_mult) accepted++;
      auto_cycle(can_mult, 1'b0);
    end
    check_eq("fill_accepted", 32'(accepted), 32'd4);
    check_eq("fill_count", 32'(count), 32'd4);
    check_eq("fill_ovf", 32'(ovf), 32'd0);
    for (int k = 0; k < 4; k++) begin
      check_eq("fill_pop", 32'(res_out), 32'(k + 1));
      cycle(1'b0, 1'b0, 1'b1, 16'h0);
    end

    // Concurrent issue and read at count=2 with two tokens in flight
    next_val = 16'h100;
    repeat (4) auto_cycle(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      auto_cycle(1'b1, 1'b1);
      check_eq("conc_count", 32'(count), 32'd2);
    end
    repeat (6) auto_cycle(1'b0, 1'b1);

    // Read on empty buffer
    cycle(1'b0, 1'b0, 1'b1, 16'h0);
    check_eq("empty_rd_count", 32'(count), 32'd0);

    // Forced write at full
    next_val = 16'h200;
    repeat (4) auto_cycle(1'b1, 1'b0);
    repeat (2) auto_cycle(1'b0, 1'b0);
    head = 16'(q[0]);
    cycle(1'b1, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'h0);
    cycle(1'b0, 1'b1, 1'b0, 16'hDEAD);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    check_eq("ovf_count", 32'(count), 32'd4);
    check_eq("ovf_head", 32'(res_out), 32'(head));
    cycle(1'b0, 1'b0, 1'b0, 16'h0);
    check_eq("ovf_sticky", 32'(ovf), 32'd1);

    // Reset with 3 buffered and 2 in flight
    do_reset(1);
    next_val = 16'h300;
    repeat (5) auto_cycle(1'b1, 1'b0);
    check_eq("mid_count", 32'(count), 32'd3);
    check_eq("mid_tok", 32'(tok), 32'd3);
    rst = 1'b1;
    ld_add = 1'b1;
    ld_mult = 1'b0;
    rd_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    tok  = '0;
    movf = 1'b0;
    check_eq("mid_rst_count", 32'(count), 32'd0);
    check_eq("mid_rst_valid", 32'(res_valid), 32'd0);
    check_eq("mid_rst_can", 32'(can_mult), 32'd1);
    repeat (4) cycle(1'b0, 1'b1, 1'b0, 16'hBEEF);
    check_eq("mid_no_late", 32'(count), 32'd0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
